// File: rtl/fb_pkg.sv
// Shared definitions for the framebuffer: default geometry, clear FSM states, address helpers.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
//
// Contents:
//   FB_DATA_W / FB_RES_X / FB_RES_Y  default pixel width and resolution
//   fb_state_e                       clear engine states (IDLE, CLEAR)
//   fb_addr()                        (x, y) -> flat row-major address
//   fb_wrap_y()                      logical row + scroll offset, wrapped into the frame
package fb_pkg;

  localparam int FB_DATA_W = 1;
  localparam int FB_RES_X  = 320;
  localparam int FB_RES_Y  = 240;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } fb_state_e;

  function automatic int unsigned fb_addr(input int unsigned x, input int unsigned y,
                                          input int unsigned res_x);
    return y * res_x + x;
  endfunction

  // Both operands are below res_y, so one conditional subtract is enough to wrap.
  function automatic int unsigned fb_wrap_y(input int unsigned y, input int unsigned scroll,
                                            input int unsigned res_y);
    int unsigned s;
    s = y + scroll;
    return (s >= res_y) ? s - res_y : s;
  endfunction

endpackage

// File: rtl/fb_mem_dp.sv
// Simple dual-port pixel RAM: one write port, one registered read port, read-first on collision.
// Latency: write commits at the clock edge; read data appears the cycle after re.
// Backpressure: none, both ports accept one access every cycle.
//
// Ports:
//   clk                  clock
//   we / waddr / wdata   write port
//   re / raddr / rdata   read port, rdata holds its value while re is low
module fb_mem_dp #(
  parameter int DATA_W = 1,
  parameter int DEPTH  = 76800,
  parameter int AW     = 17
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Both updates are non-blocking, so a same-address read gets the pre-write word.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/framebuffer_ram.sv
// Framebuffer addressed by (x, y): bounds-checked pixel read/write ports plus a full-frame clear engine.
// Latency: read data 2 cycles after rd_en; write ack/drop 1 cycle after wr_en; clear busy for RES_X*RES_Y cycles.
// Backpressure: none; writes are dropped (wr_drop) when out of range or while clearing, reads always answer.
//
// Ports:
//   clk, rst_n                       clock, synchronous active-low reset (memory contents are kept)
//   rd_en, rd_x, rd_y -> rd_data, rd_valid     scan-side pixel read, zero for out-of-range coordinates
//   wr_en, wr_x, wr_y, wr_data -> wr_ack, wr_drop   host pixel write
//   clear_req, clear_value -> busy   fill the whole frame with clear_value
//   scroll_load, scroll_rows         vertical scroll offset, present only with FB_SCROLL_EN defined
// Optional feature macro: FB_SCROLL_EN
module framebuffer_ram
  import fb_pkg::*;
#(
  parameter  int DATA_W = FB_DATA_W,
  parameter  int RES_X  = FB_RES_X,
  parameter  int RES_Y  = FB_RES_Y,
  localparam int XW     = $clog2(RES_X),
  localparam int YW     = $clog2(RES_Y),
  localparam int DEPTH  = RES_X * RES_Y,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_en,
  input  logic [XW-1:0]     rd_x,
  input  logic [YW-1:0]     rd_y,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              wr_en,
  input  logic [XW-1:0]     wr_x,
  input  logic [YW-1:0]     wr_y,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  output logic              wr_drop,
  input  logic              clear_req,
  input  logic [DATA_W-1:0] clear_value,
  output logic              busy
`ifdef FB_SCROLL_EN
  ,
  input  logic              scroll_load,
  input  logic [YW-1:0]     scroll_rows
`endif
);

  fb_state_e         state_q, state_d;
  logic [AW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] fill_q, fill_d;

  logic [YW-1:0]     rd_py, wr_py;
  logic              rd_in, wr_in, wr_accept;

  logic              rd_req_q, rd_oor_q, rd_oor_q2;
  logic [AW-1:0]     rd_addr_q;
  logic [DATA_W-1:0] mem_rdata;

  logic [AW-1:0]     wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;

  logic              mem_we;
  logic [AW-1:0]     mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  // Bounds are judged on the logical coordinate, before any scroll is applied.
  assign rd_in     = (32'(rd_x) < RES_X) && (32'(rd_y) < RES_Y);
  assign wr_in     = (32'(wr_x) < RES_X) && (32'(wr_y) < RES_Y);
  assign wr_accept = wr_en && wr_in && (state_q == IDLE);
  assign busy      = (state_q == CLEAR);

`ifdef FB_SCROLL_EN
  logic [YW-1:0] scroll_q;

  // Offsets that would point outside the frame are ignored rather than clamped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scroll_q <= '0;
    end else if (scroll_load && (32'(scroll_rows) < RES_Y)) begin
      scroll_q <= scroll_rows;
    end
  end

  assign rd_py = YW'(fb_wrap_y(32'(rd_y), 32'(scroll_q), 32'(RES_Y)));
  assign wr_py = YW'(fb_wrap_y(32'(wr_y), 32'(scroll_q), 32'(RES_Y)));
`else
  assign rd_py = rd_y;
  assign wr_py = wr_y;
`endif

  // Request stage: register coordinates as flat addresses plus the outcome flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_req_q  <= 1'b0;
      rd_oor_q  <= 1'b0;
      rd_oor_q2 <= 1'b0;
      rd_valid  <= 1'b0;
      rd_addr_q <= '0;
      wr_ack    <= 1'b0;
      wr_drop   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      rd_req_q  <= rd_en;
      rd_oor_q  <= !rd_in;
      rd_addr_q <= AW'(fb_addr(32'(rd_x), 32'(rd_py), 32'(RES_X)));
      rd_valid  <= rd_req_q;
      rd_oor_q2 <= rd_oor_q;
      wr_ack    <= wr_accept;
      wr_drop   <= wr_en && !wr_accept;
      wr_addr_q <= AW'(fb_addr(32'(wr_x), 32'(wr_py), 32'(RES_X)));
      wr_data_q <= wr_data;
    end
  end

  // Out-of-range reads never touch the array; the zero comes from this mux, which
  // also keeps rd_data at zero after reset without resetting the RAM output.
  assign rd_data = (rd_valid && !rd_oor_q2) ? mem_rdata : '0;

  // Clear engine state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      fill_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fill_q  <= fill_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fill_d  = fill_q;
    case (state_q)
      IDLE: begin
        if (clear_req) begin
          state_d = CLEAR;
          cnt_d   = '0;
          fill_d  = clear_value;
        end
      end
      CLEAR: begin
        if (cnt_q == AW'(DEPTH - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The fill owns the write port while clearing. The only host write that can be
  // committing then is one accepted in the clear_req cycle, and the fill overwrites
  // the whole frame after it anyway. Writes are suppressed during reset so an
  // aborted clear stops exactly at the counter value it had reached.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = wr_addr_q;
    mem_wdata = wr_data_q;
    if (rst_n) begin
      if (state_q == CLEAR) begin
        mem_we    = 1'b1;
        mem_waddr = cnt_q;
        mem_wdata = fill_q;
      end else begin
        mem_we = wr_ack;
      end
    end
  end

  fb_mem_dp #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (mem_wdata),
    .re    (rd_req_q && !rd_oor_q),
    .raddr (rd_addr_q),
    .rdata (mem_rdata)
  );

endmodule

// File: tb/tb_framebuffer_ram.sv
// Scoreboard bench for framebuffer_ram on a small 6x5, 4-bit frame.
// Latency: expectations carry the cycle in which the DUT must answer.
// Backpressure: n/a.
module tb_framebuffer_ram;

  localparam int DW    = 4;
  localparam int RX    = 6;
  localparam int RY    = 5;
  localparam int XW    = $clog2(RX);
  localparam int YW    = $clog2(RY);
  localparam int DEPTH = RX * RY;
`ifdef FB_SCROLL_EN
  localparam bit SCROLL = 1'b1;
`else
  localparam bit SCROLL = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rd_en, wr_en, clear_req;
  logic [XW-1:0] rd_x, wr_x;
  logic [YW-1:0] rd_y, wr_y;
  logic [DW-1:0] wr_data, clear_value, rd_data;
  logic          rd_valid, wr_ack, wr_drop, busy;
`ifdef FB_SCROLL_EN
  logic          scroll_load;
  logic [YW-1:0] scroll_rows;
`endif

  always #5 clk = ~clk;

  framebuffer_ram #(.DATA_W(DW), .RES_X(RX), .RES_Y(RY)) dut (
    .clk(clk), .rst_n(rst_n),
    .rd_en(rd_en), .rd_x(rd_x), .rd_y(rd_y), .rd_data(rd_data), .rd_valid(rd_valid),
    .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data),
    .wr_ack(wr_ack), .wr_drop(wr_drop),
    .clear_req(clear_req), .clear_value(clear_value), .busy(busy)
`ifdef FB_SCROLL_EN
    , .scroll_load(scroll_load), .scroll_rows(scroll_rows)
`endif
  );

  // ---------------- reference model ----------------
  typedef struct { int d; int due; } rexp_t;
  typedef struct { bit ack; int due; } wexp_t;
  typedef struct { int t; int a; int d; } hw_t;

  rexp_t rq[$];
  wexp_t wq[$];
  hw_t   hq[$];
  int    mdl [DEPTH];
  int    scr = 0;
  int    clr_c = -1000, clr_v = 0, fill_stop = -1000, busy_stop = -1000;
  int    cyc = 0;
  int    n_chk = 0, n_pass = 0;
  bit    mon_on = 1'b0;

  function automatic bit in_rng(input int x, input int y);
    return (x < RX) && (y < RY);
  endfunction

  function automatic int paddr(input int x, input int y);
    return ((y + scr) % RY) * RX + x;
  endfunction

  // Frame is being filled during cycles clr_c+1 .. clr_c+DEPTH (fill k lands in cycle clr_c+1+k).
  function automatic bit clearing(input int n);
    return (n >= clr_c + 1) && (n < busy_stop);
  endfunction

  function automatic bit fill_at(input int n);
    return (n - clr_c - 1 >= 0) && (n - clr_c - 1 < DEPTH) && (n < fill_stop);
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Memory contents as seen by a read issued in cycle n: every write landing up to cycle n.
  task automatic apply(input int n);
    while (hq.size() > 0 && hq[0].t <= n) begin
      if (!fill_at(n)) mdl[hq[0].a] = hq[0].d;
      void'(hq.pop_front());
    end
    if (fill_at(n)) mdl[n - clr_c - 1] = clr_v;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drive(input bit re, input int rx, input int ry,
                       input bit we, input int wx, input int wy, input int wd,
                       input bit clr, input int cv, input bit sl, input int sr);
    int n;
    bit acc;
    rexp_t e;
    wexp_t w;
    hw_t   h;
    n = cyc;
    rd_en = re; rd_x = XW'(rx); rd_y = YW'(ry);
    wr_en = we; wr_x = XW'(wx); wr_y = YW'(wy); wr_data = DW'(wd);
    clear_req = clr; clear_value = DW'(cv);
`ifdef FB_SCROLL_EN
    scroll_load = sl; scroll_rows = YW'(sr);
`endif
    apply(n);
    if (re) begin
      e.due = n + 2;
      e.d   = in_rng(rx, ry) ? mdl[paddr(rx, ry)] : 0;
      rq.push_back(e);
    end
    if (we) begin
      acc   = in_rng(wx, wy) && !clearing(n);
      w.ack = acc;
      w.due = n + 1;
      wq.push_back(w);
      if (acc) begin
        h.t = n + 1; h.a = paddr(wx, wy); h.d = wd;
        hq.push_back(h);
      end
    end
    if (clr && !clearing(n)) begin
      clr_c = n; clr_v = cv;
      fill_stop = n + 1 + DEPTH; busy_stop = n + 1 + DEPTH;
    end
    if (SCROLL && sl && sr < RY) scr = sr;
    tick();
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic rd(input int x, input int y);
    drive(1, x, y, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic wr(input int x, input int y, input int d);
    drive(0, 0, 0, 1, x, y, d, 0, 0, 0, 0);
  endtask

  task automatic read_all();
    for (int k = 0; k < DEPTH; k++) rd(k % RX, k / RX);
    idle(3);
  endtask

  task automatic do_reset();
    int n;
    n = cyc;
    rd_en = 0; wr_en = 0; clear_req = 0;
`ifdef FB_SCROLL_EN
    scroll_load = 0;
`endif
    rst_n = 1'b0;
    hq.delete();
    if (fill_stop > n) fill_stop = n;
    if (busy_stop > n + 1) busy_stop = n + 1;
    scr = 0;
    tick();
    rst_n = 1'b1;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (mon_on) begin
      rexp_t e;
      wexp_t w;
      chk("busy", int'(busy), int'(clearing(cyc)));
      if (rd_valid) begin
        if (rq.size() == 0) begin
          n_chk++;
          $display("FAIL rd_unexpected: rd_valid high with nothing outstanding (cycle %0d)", cyc);
        end else begin
          e = rq.pop_front();
          chk("rd_data", int'(rd_data), e.d);
          chk("rd_latency", cyc, e.due);
        end
      end
      if (wr_ack || wr_drop) begin
        if (wq.size() == 0) begin
          n_chk++;
          $display("FAIL wr_unexpected: ack=%0d drop=%0d with nothing outstanding (cycle %0d)",
                   wr_ack, wr_drop, cyc);
        end else begin
          w = wq.pop_front();
          chk("wr_ack", int'(wr_ack), int'(w.ack));
          chk("wr_drop", int'(wr_drop), int'(!w.ack));
          chk("wr_latency", cyc, w.due);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int bcnt;
    rst_n = 1'b0;
    rd_en = 0; wr_en = 0; clear_req = 0;
    rd_x = '0; rd_y = '0; wr_x = '0; wr_y = '0; wr_data = '0; clear_value = '0;
`ifdef FB_SCROLL_EN
    scroll_load = 0; scroll_rows = '0;
`endif
    repeat (3) tick();
    rst_n = 1'b1;
    chk("reset_rd_valid", int'(rd_valid), 0);
    chk("reset_rd_data", int'(rd_data), 0);
    chk("reset_wr_ack", int'(wr_ack), 0);
    chk("reset_wr_drop", int'(wr_drop), 0);
    chk("reset_busy", int'(busy), 0);
    mon_on = 1'b1;

    // Known frame contents first.
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    idle(DEPTH + 2);

    // Basic write then read at the far corner; out-of-range accesses.
    wr(5, 4, 1);
    rd(5, 4);
    wr(6, 0, 9);
    wr(0, 5, 9);
    wr(7, 7, 9);
    rd(6, 0);
    rd(0, 5);
    rd(0, 0);
    idle(3);

    // Same-cycle read and write, then read the new value.
    wr(3, 2, 6);
    idle(2);
    drive(1, 3, 2, 1, 3, 2, 12, 0, 0, 0, 0);
    rd(3, 2);
    idle(3);

    // Clear to 0xA: write in the request cycle is accepted, write while busy dropped,
    // a second request mid-clear ignored, busy high for exactly DEPTH cycles.
    drive(0, 0, 0, 1, 2, 3, 7, 1, 'hA, 0, 0);
    bcnt = 0;
    for (int i = 0; i < DEPTH + 4; i++) begin
      if (busy) bcnt++;
      if (i == 0) wr(1, 1, 3);
      else if (i == 4) drive(0, 0, 0, 0, 0, 0, 0, 1, 'h3, 0, 0);
      else if (i == 7) rd(0, 0);
      else idle(1);
    end
    chk("busy_cycles", bcnt, DEPTH);
    read_all();

    // Clear aborted by reset at counter 10: pixels 0..9 take 0x5, the rest keep 0xA.
    wr(4, 3, 2);
    idle(2);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 'h5, 0, 0);
    idle(10);
    do_reset();
    chk("abort_busy", int'(busy), 0);
    read_all();

`ifdef FB_SCROLL_EN
    // Scroll by 3, write logical row 2, reject an offset equal to RES_Y, read back unscrolled.
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3);
    wr(0, 2, 13);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, RY);
    rd(0, 2);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    rd(0, 0);
    idle(3);
`endif

    // Randomised mix of reads, writes (some out of range), clears and scroll loads.
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(1, 0), $urandom_range(7, 0), $urandom_range(7, 0),
            $urandom_range(1, 0), $urandom_range(7, 0), $urandom_range(7, 0),
            $urandom_range(15, 0), ($urandom_range(59, 0) == 0), $urandom_range(15, 0),
            ($urandom_range(19, 0) == 0), $urandom_range(7, 0));
    end
    idle(DEPTH + 4);
    read_all();

    idle(4);
    chk("rd_outstanding", rq.size(), 0);
    chk("wr_outstanding", wq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
